kuz_lin_transform: RTL and testbench

Sequential implementation of the Kuznyechik (GOST R 34.12-2015) linear transformation L = R^16 on a 128-bit block.
- Sits directly downstream of the 16-byte nonlinear substitution layer (16 parallel pi S-boxes) in each encryption round.
- Output feeds the next round-key XOR.
- Iterates the byte-shift R step over GF(2^8), with a valid/ready handshake on both sides.

---
 rtl/kuz_pkg.sv | 37 +++
 rtl/kuz_r_step.sv | 26 ++
 rtl/kuz_lin_transform.sv | 102 ++++++++++
 tb/tb_kuz_lin_transform.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kuz_pkg.sv
// Shared types, constants and GF(2^8) helper for the Kuznyechik linear layer.
// Field: GF(2^8) modulo x^8+x^7+x^6+x+1 (0x1C3). Addition is XOR.
package kuz_pkg;

  typedef logic [127:0] block_t;
  typedef logic [7:0]   byte_t;

  // Low byte of 0x1C3; the x^8 term is implied by the carry out of bit 7.
  localparam byte_t GF_POLY = 8'hC3;

  // l-function coefficients. Index 0 multiplies a15 and index 15 multiplies a0.
  localparam byte_t L_COEF [16] = '{
    8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
    8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shift-and-add multiply. When b is a constant, synthesis folds this into
  // a small XOR network.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/kuz_r_step.sv
// One combinational Kuznyechik R step:
//   R(a15..a0) = l(a15..a0) || a15..a1
// i.e. shift the block right by one byte and place l() in the top byte.
// Ports:
//   blk_i  128-bit input block (a15 = [127:120], a0 = [7:0])
//   blk_o  128-bit R(blk_i)
module kuz_r_step
  import kuz_pkg::*;
(
  input  logic [127:0] blk_i,
  output logic [127:0] blk_o
);

  byte_t l_byte;

  // Byte a(15-i) sits at [8*(15-i) +: 8] and takes coefficient L_COEF[i].
  always_comb begin
    l_byte = '0;
    for (int i = 0; i < 16; i++) begin
      l_byte = l_byte ^ gf_mul(blk_i[8*(15-i) +: 8], L_COEF[i]);
    end
  end

  assign blk_o = {l_byte, blk_i[127:8]};

endmodule

// File: rtl/kuz_lin_transform.sv
// Kuznyechik linear transformation L = R^16, computed iteratively with RPC
// chained R steps per clock (latency 16/RPC cycles).
// Ports:
//   clk_i    system clock (rising edge)
//   rstn_i   asynchronous active-low reset
//   valid_i  input block valid
//   ready_o  block can be accepted (IDLE, or DONE while ready_i is high)
//   data_i   input block, a15 = [127:120], a0 = [7:0]
//   valid_o  result valid (DONE)
//   ready_i  downstream accepts result
//   data_o   L(data_i), driven straight from the data register
// Parameter:
//   RPC      R steps per clock: 1, 2, 4, 8 or 16
module kuz_lin_transform
  import kuz_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o
);

  localparam logic [4:0] STEP = 5'(RPC);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  block_t      data_q, data_d;

  // chain[0] is the register and chain[RPC] is the value after RPC R steps.
  block_t      chain [RPC+1];

  assign chain[0] = data_q;

  for (genvar g = 0; g < RPC; g++) begin : g_chain
    kuz_r_step u_step (
      .blk_i (chain[g]),
      .blk_o (chain[g+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          data_d  = data_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        data_d = chain[RPC];
        cnt_d  = cnt_q + STEP;
        if (cnt_d == 5'd16) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        // Ready only while the result is being taken, so a new block is
        // captured on the same edge and no cycle is lost.
        ready_o = ready_i;
        if (ready_i) begin
          if (valid_i) begin
            data_d  = data_i;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_kuz_lin_transform.sv
// Directed bench for kuz_lin_transform: RPC=1, 4 and 16 instances on one clock,
// plus a standalone R step.
module tb_kuz_lin_transform;

  localparam logic [127:0] V_A   = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] V_B   = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  localparam logic [127:0] V_C   = 128'h79d26221b87b584cd42fbc4ffea5de9a;
  localparam logic [127:0] R_IN  = 128'h00000000000000000000000000000100;
  localparam logic [127:0] R_O1  = 128'h94000000000000000000000000000001;
  localparam logic [127:0] R_O2  = 128'ha5940000000000000000000000000000;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [2:0]   vld_i = '0;
  logic [2:0]   rdy_i = '1;
  logic [2:0]   rdy_o;
  logic [2:0]   vld_o;
  logic [127:0] din [3];
  logic [127:0] dout [3];
  logic [127:0] rs_in, rs_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kuz_lin_transform #(.RPC(1)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(vld_i[0]), .ready_o(rdy_o[0]),
    .data_i(din[0]), .valid_o(vld_o[0]), .ready_i(rdy_i[0]), .data_o(dout[0]));

  kuz_lin_transform #(.RPC(4)) u_dut4 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(vld_i[1]), .ready_o(rdy_o[1]),
    .data_i(din[1]), .valid_o(vld_o[1]), .ready_i(rdy_i[1]), .data_o(dout[1]));

  kuz_lin_transform #(.RPC(16)) u_dut16 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(vld_i[2]), .ready_o(rdy_o[2]),
    .data_i(din[2]), .valid_o(vld_o[2]), .ready_i(rdy_i[2]), .data_o(dout[2]));

  kuz_r_step u_rs (.blk_i(rs_in), .blk_o(rs_out));

  // From a negedge, count clocks until valid_o is seen (bounded).
  task automatic wait_valid(input int idx, output int k);
    k = 0;
    while (!vld_o[idx] && k < 100) begin
      @(posedge clk); @(negedge clk); k++;
    end
  endtask

  // Send one block, check latency and result, and let it be consumed.
  task automatic run_block(input int idx, input logic [127:0] in,
                           input logic [127:0] exp, input int lat, input string nm);
    int t, k;
    @(negedge clk);
    t = 0;
    while (!rdy_o[idx] && t < 100) begin @(negedge clk); t++; end
    n_cmp++;
    if (rdy_o[idx] !== 1'b1) begin
      n_err++; $display("FAIL %s ready_o: got %b want 1", nm, rdy_o[idx]);
    end
    vld_i[idx] = 1'b1; din[idx] = in;
    @(posedge clk);
    @(negedge clk);
    vld_i[idx] = 1'b0;
    wait_valid(idx, k);
    n_cmp++;
    if (k !== lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", nm, k, lat);
    end
    n_cmp++;
    if (dout[idx] !== exp) begin
      n_err++; $display("FAIL %s data_o: got %h want %h", nm, dout[idx], exp);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (vld_o[idx] !== 1'b0) begin
      n_err++; $display("FAIL %s valid_o after consume: got %b want 0", nm, vld_o[idx]);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdy_o[i] !== 1'b1 || vld_o[i] !== 1'b0 || dout[i] !== '0) begin
        n_err++;
        $display("FAIL reset[%0d]: ready=%b valid=%b data=%h want 1 0 0", i, rdy_o[i], vld_o[i], dout[i]);
      end
    end
  endtask

  task automatic test_r_step;
    rs_in = R_IN; #1;
    n_cmp++;
    if (rs_out !== R_O1) begin
      n_err++; $display("FAIL r_step1: got %h want %h", rs_out, R_O1);
    end
    rs_in = R_O1; #1;
    n_cmp++;
    if (rs_out !== R_O2) begin
      n_err++; $display("FAIL r_step2: got %h want %h", rs_out, R_O2);
    end
  endtask

  task automatic test_single;
    run_block(0, V_A, V_B, 16, "single_a");
    run_block(0, V_B, V_C, 16, "single_b");
  endtask

  task automatic test_backpressure;
    int k;
    rdy_i[0] = 1'b0;
    @(negedge clk);
    vld_i[0] = 1'b1; din[0] = V_A;
    @(posedge clk);
    @(negedge clk);
    vld_i[0] = 1'b0;
    wait_valid(0, k);
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (vld_o[0] !== 1'b1 || dout[0] !== V_B || rdy_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL stall c%0d: valid=%b ready=%b data=%h want 1 0 %h", c, vld_o[0], rdy_o[0], dout[0], V_B);
      end
      @(negedge clk);
    end
    rdy_i[0] = 1'b1;
    #1;
    n_cmp++;
    if (rdy_o[0] !== 1'b1 || vld_o[0] !== 1'b1) begin
      n_err++; $display("FAIL release: ready=%b valid=%b want 1 1", rdy_o[0], vld_o[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (vld_o[0] !== 1'b0 || rdy_o[0] !== 1'b1) begin
      n_err++; $display("FAIL post_release: valid=%b ready=%b want 0 1", vld_o[0], rdy_o[0]);
    end
  endtask

  task automatic test_back_to_back;
    int k1, k2;
    @(negedge clk);
    vld_i[0] = 1'b1; din[0] = V_A;
    @(posedge clk);
    @(negedge clk);
    din[0] = V_B;
    wait_valid(0, k1);
    n_cmp++;
    if (k1 !== 16 || dout[0] !== V_B || rdy_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: lat=%0d data=%h ready=%b want 16 %h 1", k1, dout[0], rdy_o[0], V_B);
    end
    @(posedge clk);
    @(negedge clk);
    vld_i[0] = 1'b0;
    n_cmp++;
    if (vld_o[0] !== 1'b0 || rdy_o[0] !== 1'b0) begin
      n_err++; $display("FAIL b2b_gap: valid=%b ready=%b want 0 0", vld_o[0], rdy_o[0]);
    end
    wait_valid(0, k2);
    n_cmp++;
    if (k2 !== 16 || dout[0] !== V_C) begin
      n_err++; $display("FAIL b2b_second: lat=%0d data=%h want 16 %h", k2, dout[0], V_C);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy;
    int seen;
    @(negedge clk);
    vld_i[0] = 1'b1; din[0] = V_A;
    @(posedge clk);
    @(negedge clk);
    vld_i[0] = 1'b0;
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (vld_o[0] !== 1'b0 || dout[0] !== '0) begin
      n_err++; $display("FAIL mid_reset: valid=%b data=%h want 0 0", vld_o[0], dout[0]);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy_o[0] !== 1'b1) begin
      n_err++; $display("FAIL mid_reset ready_o: got %b want 1", rdy_o[0]);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (vld_o[0]) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL stale_result: valid cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_rpc;
    run_block(1, V_A, V_B, 4, "rpc4_a");
    run_block(1, V_B, V_C, 4, "rpc4_b");
    run_block(1, '0, '0, 4, "rpc4_zero");
    run_block(2, V_A, V_B, 1, "rpc16_a");
    run_block(2, V_B, V_C, 1, "rpc16_b");
    run_block(2, '0, '0, 1, "rpc16_zero");
    run_block(0, '0, '0, 16, "rpc1_zero");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) din[i] = '0;
    rs_in = '0;
    test_reset();
    test_r_step();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_rpc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
